// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings and the operand bundle used by
// requesters of the shared ALU.
package alu_pkg;

   localparam int ALU_OP_W   = 3;
   localparam int ALU_DATA_W = 32;

   localparam logic [ALU_OP_W-1:0] OP_ADD  = 3'b000;
   localparam logic [ALU_OP_W-1:0] OP_SLL  = 3'b001;
   localparam logic [ALU_OP_W-1:0] OP_SLT  = 3'b010;
   localparam logic [ALU_OP_W-1:0] OP_SLTU = 3'b011;
   localparam logic [ALU_OP_W-1:0] OP_XOR  = 3'b100;
   localparam logic [ALU_OP_W-1:0] OP_SR   = 3'b101;
   localparam logic [ALU_OP_W-1:0] OP_OR   = 3'b110;
   localparam logic [ALU_OP_W-1:0] OP_AND  = 3'b111;

   // alt selects SUB for OP_ADD and arithmetic shift for OP_SR
   typedef struct packed {
      logic [ALU_DATA_W-1:0] a;
      logic [ALU_DATA_W-1:0] b;
      logic [ALU_OP_W-1:0]   op;
      logic                  alt;
   } alu_req_t;

endpackage

// File: rtl/alu.sv
// Purely combinational integer ALU. Shift amount is src_b[4:0]; all results
// wrap to DATA_W bits.
module alu
   import alu_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0]   src_a,
   input  logic [DATA_W-1:0]   src_b,
   input  logic [ALU_OP_W-1:0] op,
   input  logic                alt,
   output logic [DATA_W-1:0]   res
);

   logic [4:0]               shamt;
   logic signed [DATA_W-1:0] sra;
   logic [DATA_W-1:0]        srl;
   logic                     lt_s;
   logic                     lt_u;

   assign shamt = src_b[4:0];
   // kept in a signed variable so >>> stays arithmetic regardless of context
   assign sra   = $signed(src_a) >>> shamt;
   assign srl   = src_a >> shamt;
   assign lt_s  = $signed(src_a) < $signed(src_b);
   assign lt_u  = src_a < src_b;

   always_comb begin
      res = '0;
      case (op)
         OP_ADD:  res = alt ? (src_a - src_b) : (src_a + src_b);
         OP_SLL:  res = src_a << shamt;
         OP_SLT:  res = {{(DATA_W-1){1'b0}}, lt_s};
         OP_SLTU: res = {{(DATA_W-1){1'b0}}, lt_u};
         OP_XOR:  res = src_a ^ src_b;
         OP_SR:   res = alt ? $unsigned(sra) : srl;
         OP_OR:   res = src_a | src_b;
         OP_AND:  res = src_a & src_b;
         default: res = '0;
      endcase
   end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts at rr_ptr and wraps; the pointer moves
// past the winner only when the grant is actually taken (advance).
module rr_arbiter #(
   parameter int N_REQ = 2,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   input  logic             advance,
   output logic [N_REQ-1:0] grant,
   output logic [ID_W-1:0]  grant_id
);

   logic [ID_W-1:0] rr_ptr;
   logic            found;

   // two passes: indices at/after rr_ptr first, then the wrapped ones below it
   always_comb begin
      grant    = '0;
      grant_id = '0;
      found    = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (!found && req[i] && (i >= int'(rr_ptr))) begin
            found    = 1'b1;
            grant[i] = 1'b1;
            grant_id = ID_W'(i);
         end
      end
      for (int i = 0; i < N_REQ; i++) begin
         if (!found && req[i] && (i < int'(rr_ptr))) begin
            found    = 1'b1;
            grant[i] = 1'b1;
            grant_id = ID_W'(i);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= '0;
      end else if (advance) begin
         rr_ptr <= (int'(grant_id) == N_REQ - 1) ? '0 : grant_id + 1'b1;
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU among N_REQ requesters: round-robin accept into an operand
// register (S1), ALU result into a result register (S2), in-order responses.
module alu_arbiter #(
   parameter int DATA_W   = 32,
   parameter int ALU_OP_W = 3,
   parameter int N_REQ    = 2,
   parameter int ID_W     = $clog2(N_REQ)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [N_REQ-1:0]           req_valid,
   output logic [N_REQ-1:0]           req_ready,
   input  logic [N_REQ*DATA_W-1:0]    req_a,
   input  logic [N_REQ*DATA_W-1:0]    req_b,
   input  logic [N_REQ*ALU_OP_W-1:0]  req_op,
   input  logic [N_REQ-1:0]           req_alt,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [DATA_W-1:0]          rsp_res,
   output logic [ID_W-1:0]            rsp_id
);

   typedef struct packed {
      logic [DATA_W-1:0]   a;
      logic [DATA_W-1:0]   b;
      logic [ALU_OP_W-1:0] op;
      logic                alt;
   } s1_req_t;

   logic [N_REQ-1:0]  grant;
   logic [ID_W-1:0]   grant_id;
   logic              s1_free;
   logic              s2_free;
   logic              accept;

   s1_req_t           s1_nxt;
   s1_req_t           s1_req;
   logic [ID_W-1:0]   s1_id;
   logic              s1_valid;

   logic [DATA_W-1:0] alu_res;
   logic [DATA_W-1:0] s2_res;
   logic [ID_W-1:0]   s2_id;
   logic              s2_valid;

   assign s2_free = !s2_valid || rsp_ready;
   assign s1_free = !s1_valid || s2_free;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_arb (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req_valid),
      .advance  (accept),
      .grant    (grant),
      .grant_id (grant_id)
   );

   // ready is gated by rst_n so nothing is offered while reset is held
   assign req_ready = rst_n ? (grant & {N_REQ{s1_free}}) : '0;
   assign accept    = |(req_valid & req_ready);

   always_comb begin
      s1_nxt = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant[i]) begin
            s1_nxt.a   = req_a[i*DATA_W +: DATA_W];
            s1_nxt.b   = req_b[i*DATA_W +: DATA_W];
            s1_nxt.op  = req_op[i*ALU_OP_W +: ALU_OP_W];
            s1_nxt.alt = req_alt[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_req   <= '0;
         s1_id    <= '0;
      end else if (accept) begin
         s1_valid <= 1'b1;
         s1_req   <= s1_nxt;
         s1_id    <= grant_id;
      end else if (s2_free) begin
         s1_valid <= 1'b0;
      end
   end

   alu #(
      .DATA_W (DATA_W)
   ) u_alu (
      .src_a (s1_req.a),
      .src_b (s1_req.b),
      .op    (s1_req.op),
      .alt   (s1_req.alt),
      .res   (alu_res)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         s2_res   <= '0;
         s2_id    <= '0;
      end else if (s1_valid && s2_free) begin
         s2_valid <= 1'b1;
         s2_res   <= alu_res;
         s2_id    <= s1_id;
      end else if (rsp_ready) begin
         s2_valid <= 1'b0;
      end
   end

   assign rsp_valid = s2_valid;
   assign rsp_res   = s2_res;
   assign rsp_id    = s2_id;

   // a requester must keep valid up until it is accepted
   for (genvar i = 0; i < N_REQ; i++) begin : g_hold
      a_hold: assert property (@(posedge clk) disable iff (!rst_n)
         (req_valid[i] && !req_ready[i]) |=> req_valid[i]);
   end

   a_onehot: assert property (@(posedge clk) $onehot0(req_ready));

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed table of ALU vectors, handshake corner
// sequences, then random traffic against a queue-based reference model.
module tb_alu_arbiter;
   import alu_pkg::*;

   localparam int DW = 32;
   localparam int OW = 3;
   localparam int NR = 2;
   localparam int IW = 1;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NR-1:0]     req_valid;
   logic [NR-1:0]     req_ready;
   logic [NR*DW-1:0]  req_a;
   logic [NR*DW-1:0]  req_b;
   logic [NR*OW-1:0]  req_op;
   logic [NR-1:0]     req_alt;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DW-1:0]     rsp_res;
   logic [IW-1:0]     rsp_id;

   always #5 clk = ~clk;

   alu_arbiter #(.DATA_W(DW), .ALU_OP_W(OW), .N_REQ(NR), .ID_W(IW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_op    (req_op),
      .req_alt   (req_alt),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_res   (rsp_res),
      .rsp_id    (rsp_id)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] alu_ref(input alu_req_t r);
      int sh;
      sh = int'(r.b[4:0]);
      case (r.op)
         OP_ADD:  return r.alt ? r.a - r.b : r.a + r.b;
         OP_SLL:  return r.a << sh;
         OP_SLT:  return ($signed(r.a) < $signed(r.b)) ? 32'd1 : 32'd0;
         OP_SLTU: return (r.a < r.b) ? 32'd1 : 32'd0;
         OP_XOR:  return r.a ^ r.b;
         OP_SR: begin
            logic signed [31:0] s;
            s = $signed(r.a) >>> sh;
            return r.alt ? $unsigned(s) : r.a >> sh;
         end
         OP_OR:   return r.a | r.b;
         default: return r.a & r.b;
      endcase
   endfunction

   function automatic alu_req_t mk(input logic [2:0] op, input logic alt,
                                   input logic [31:0] a, input logic [31:0] b);
      alu_req_t r;
      r.a = a; r.b = b; r.op = op; r.alt = alt;
      return r;
   endfunction

   task automatic drive(input int i, input alu_req_t r);
      req_valid[i]          = 1'b1;
      req_a[i*DW +: DW]     = r.a;
      req_b[i*DW +: DW]     = r.b;
      req_op[i*OW +: OW]    = r.op;
      req_alt[i]            = r.alt;
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      req_valid = '0;
      rsp_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // single op on one requester; returns the req_ready seen in its cycle
   task automatic one_op(input int id, input alu_req_t r, output logic [NR-1:0] rdy);
      drive(id, r);
      @(negedge clk);
      rdy = req_ready;
      next_cyc();
      req_valid[id] = 1'b0;
   endtask

   function automatic alu_req_t bp_op(input int k);
      logic [31:0] kk;
      kk = 32'(k);
      return mk(kk[0] ? OP_XOR : OP_ADD, 1'b0, 32'h0101_0000 * kk + 32'h55, kk * 32'h10);
   endfunction

   typedef struct {
      alu_req_t    r;
      int          id;
      logic [31:0] exp;
   } vec_t;

   typedef struct {
      logic [31:0] res;
      int          id;
      int          cyc;
   } exp_t;

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached before the bench finished");
      $fatal(1);
   end

   initial begin
      vec_t        tbl[15];
      logic [NR-1:0] rdy;
      exp_t        q[$];
      alu_req_t    pend[NR];
      logic [NR-1:0] acc;
      int          ptr;
      int          sent, got;

      tbl[0]  = '{mk(OP_ADD,  1'b0, 32'd5,          32'd3),          0, 32'd8};
      tbl[1]  = '{mk(OP_ADD,  1'b1, 32'd10,         32'd3),          1, 32'd7};
      tbl[2]  = '{mk(OP_SR,   1'b1, 32'h8000_0000,  32'd4),          0, 32'hF800_0000};
      tbl[3]  = '{mk(OP_SR,   1'b0, 32'h8000_0000,  32'd4),          1, 32'h0800_0000};
      tbl[4]  = '{mk(OP_SLT,  1'b0, 32'hFFFF_FFFF,  32'd1),          0, 32'd1};
      tbl[5]  = '{mk(OP_SLTU, 1'b0, 32'hFFFF_FFFF,  32'd1),          1, 32'd0};
      tbl[6]  = '{mk(OP_SLL,  1'b0, 32'd1,          32'd31),         0, 32'h8000_0000};
      tbl[7]  = '{mk(OP_SLL,  1'b0, 32'd1,          32'd33),         1, 32'd2};
      tbl[8]  = '{mk(OP_XOR,  1'b0, 32'hF0F0_F0F0,  32'hFF00_FF00),  0, 32'h0FF0_0FF0};
      tbl[9]  = '{mk(OP_OR,   1'b0, 32'hF0F0_F0F0,  32'h0F0F_0000),  1, 32'hFFFF_F0F0};
      tbl[10] = '{mk(OP_AND,  1'b0, 32'hF0F0_F0F0,  32'hFF00_FF00),  0, 32'hF000_F000};
      tbl[11] = '{mk(OP_ADD,  1'b1, 32'd0,          32'd1),          1, 32'hFFFF_FFFF};
      tbl[12] = '{mk(OP_ADD,  1'b0, 32'hFFFF_FFFF,  32'd2),          0, 32'd1};
      tbl[13] = '{mk(OP_SLT,  1'b0, 32'd1,          32'hFFFF_FFFF),  1, 32'd0};
      tbl[14] = '{mk(OP_SLTU, 1'b0, 32'd1,          32'hFFFF_FFFF),  0, 32'd1};

      // reset state, with requests already pending
      rst_n     = 1'b0;
      rsp_ready = 1'b1;
      req_valid = '0; req_a = '0; req_b = '0; req_op = '0; req_alt = '0;
      drive(0, tbl[0].r);
      drive(1, tbl[1].r);
      next_cyc();
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_res",   rsp_res,   0);
      chk("rst_rsp_id",    rsp_id,    0);
      chk("rst_req_ready", req_ready, 0);
      req_valid = '0;
      next_cyc();
      rst_n = 1'b1;

      // table: one op at a time, ready same cycle, result two cycles later
      for (int k = 0; k < 15; k++) begin
         drive(tbl[k].id, tbl[k].r);
         @(negedge clk);
         chk($sformatf("vec%0d_ready", k), req_ready, 64'(1) << tbl[k].id);
         next_cyc();
         req_valid = '0;
         @(negedge clk);
         chk($sformatf("vec%0d_early", k), rsp_valid, 0);
         next_cyc();
         @(negedge clk);
         chk($sformatf("vec%0d_valid", k), rsp_valid, 1);
         chk($sformatf("vec%0d_res", k),   rsp_res,   tbl[k].exp);
         chk($sformatf("vec%0d_id", k),    rsp_id,    tbl[k].id);
         next_cyc();
      end

      // both requesters valid from reset: alternating grants, 1 rsp/cycle
      rst_n = 1'b0;
      drive(0, mk(OP_ADD, 1'b1, 32'd10, 32'd3));
      drive(1, mk(OP_SR,  1'b1, 32'h8000_0000, 32'd4));
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         chk($sformatf("rr%0d_ready", c), req_ready, (c % 2 == 0) ? 2'b01 : 2'b10);
         if (c >= 2) begin
            chk($sformatf("rr%0d_valid", c), rsp_valid, 1);
            chk($sformatf("rr%0d_id", c), rsp_id, (c - 2) % 2);
            chk($sformatf("rr%0d_res", c), rsp_res,
                ((c - 2) % 2 == 1) ? 32'hF800_0000 : 32'd7);
         end
         next_cyc();
      end
      req_valid[1] = 1'b0;
      @(negedge clk);
      chk("rr_tail_ready", req_ready, 2'b01);
      next_cyc();
      req_valid = '0;
      repeat (4) next_cyc();

      // backpressure: 6 ops from req0, downstream stalled for 5 cycles
      rsp_ready = 1'b0;
      sent = 0;
      got  = 0;
      for (int c = 0; c < 40 && got < 6; c++) begin
         if (c == 5) rsp_ready = 1'b1;
         if (sent < 6) drive(0, bp_op(sent));
         else req_valid[0] = 1'b0;
         @(negedge clk);
         if (c < 5) begin
            chk($sformatf("bp%0d_ready", c), req_ready, (c < 2) ? 2'b01 : 2'b00);
            if (c >= 2) begin
               chk($sformatf("bp%0d_valid", c), rsp_valid, 1);
               chk($sformatf("bp%0d_hold_res", c), rsp_res, alu_ref(bp_op(0)));
               chk($sformatf("bp%0d_hold_id", c), rsp_id, 0);
            end
         end
         if (req_valid[0] && req_ready[0]) sent++;
         if (rsp_valid && rsp_ready) begin
            chk($sformatf("bp_res%0d", got), rsp_res, alu_ref(bp_op(got)));
            chk($sformatf("bp_id%0d", got), rsp_id, 0);
            got++;
         end
         next_cyc();
      end
      req_valid = '0;
      chk("bp_count", got, 6);
      repeat (2) next_cyc();

      // fairness and pointer stability over idle cycles
      one_op(1, tbl[0].r, rdy);
      chk("fair_solo1", rdy, 2'b10);
      repeat (3) next_cyc();
      drive(0, tbl[2].r);
      drive(1, tbl[3].r);
      @(negedge clk);
      chk("fair_both_a", req_ready, 2'b01);
      next_cyc();
      req_valid[0] = 1'b0;
      @(negedge clk);
      chk("fair_rest_a", req_ready, 2'b10);
      next_cyc();
      req_valid = '0;
      one_op(0, tbl[4].r, rdy);
      chk("fair_solo0", rdy, 2'b01);
      repeat (3) next_cyc();
      drive(0, tbl[5].r);
      drive(1, tbl[6].r);
      @(negedge clk);
      chk("fair_both_b", req_ready, 2'b10);
      next_cyc();
      req_valid[1] = 1'b0;
      @(negedge clk);
      chk("fair_rest_b", req_ready, 2'b01);
      next_cyc();
      req_valid = '0;
      repeat (3) next_cyc();

      // reset with S1 and S2 occupied
      rsp_ready = 1'b0;
      one_op(0, tbl[8].r, rdy);
      chk("rstmid_acc0", rdy, 2'b01);
      one_op(0, tbl[9].r, rdy);
      chk("rstmid_acc1", rdy, 2'b01);
      @(negedge clk);
      chk("rstmid_full", rsp_valid, 1);
      #2;
      drive(0, mk(OP_ADD, 1'b0, 32'd7, 32'd8));
      drive(1, mk(OP_OR,  1'b0, 32'h10, 32'h01));
      rst_n = 1'b0;
      #1;
      chk("rstmid_valid", rsp_valid, 0);
      chk("rstmid_ready", req_ready, 0);
      chk("rstmid_res",   rsp_res,   0);
      rsp_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rstrel_grant0", req_ready, 2'b01);
      chk("rstrel_stale0", rsp_valid, 0);
      next_cyc();
      req_valid[0] = 1'b0;
      @(negedge clk);
      chk("rstrel_grant1", req_ready, 2'b10);
      chk("rstrel_stale1", rsp_valid, 0);
      next_cyc();
      req_valid = '0;
      @(negedge clk);
      chk("rstrel_valid", rsp_valid, 1);
      chk("rstrel_res",   rsp_res,   32'd15);
      chk("rstrel_id",    rsp_id,    0);
      next_cyc();

      // random traffic against the reference model
      do_reset();
      acc = '0;
      ptr = 0;
      for (int cyc = 0; cyc < 1700; cyc++) begin
         if (cyc >= 1500 && q.size() == 0 && req_valid == '0) break;
         for (int i = 0; i < NR; i++) begin
            if (!req_valid[i] || acc[i]) begin
               if (cyc < 1500 && $urandom_range(99) < 60) begin
                  logic [31:0] ra, rb;
                  ra = ($urandom_range(3) == 0) ? 32'h8000_0000 >> $urandom_range(1) : $urandom;
                  rb = ($urandom_range(3) == 0) ? 32'($urandom_range(40)) : $urandom;
                  pend[i] = mk(3'($urandom_range(7)), 1'($urandom_range(1)), ra, rb);
                  drive(i, pend[i]);
               end else begin
                  req_valid[i] = 1'b0;
               end
            end
         end
         rsp_ready = (cyc >= 1500) ? 1'b1 : ($urandom_range(99) < 70);
         @(negedge clk);
         begin
            logic          exp_v, ok;
            int            g;
            logic [NR-1:0] exp_rdy;
            exp_v = (q.size() > 0) && (cyc >= q[0].cyc + 2);
            chk("rnd_rsp_valid", rsp_valid, exp_v);
            if (exp_v && rsp_valid) begin
               chk("rnd_res", rsp_res, q[0].res);
               chk("rnd_id",  rsp_id,  q[0].id);
            end
            ok = (q.size() < 2) || rsp_ready;
            g  = -1;
            for (int k = 0; k < NR; k++) begin
               int idx;
               idx = (ptr + k) % NR;
               if (g < 0 && req_valid[idx]) g = idx;
            end
            exp_rdy = (ok && g >= 0) ? NR'(1) << g : '0;
            chk("rnd_ready", req_ready, exp_rdy);
            acc = req_valid & req_ready;
            if (exp_v && rsp_ready) void'(q.pop_front());
            if (ok && g >= 0) begin
               q.push_back('{alu_ref(pend[g]), g, cyc});
               ptr = (g + 1) % NR;
            end
         end
         next_cyc();
      end
      chk("rnd_drained", q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
